// File: rtl/blit_pkg.sv
// Shared types and constants for the sprite blitter and related raster blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package blit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Visible VGA area; pixels at or beyond these are off-screen.
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 7;
  localparam int DEF_COLOR_W = 3;

  // Counter width for an n-entry scan; a 1-entry scan still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order (cx, cy) scan counter over a W x H block; cx fastest.
// Latency: counters update on the clock edge where en is high; last is combinational.
// Backpressure: none; the scan only moves when en is asserted, clear has priority.
//
// Ports: clock, resetn (async, active low), clear, en -> cx, cy, last.
module raster_counter
  import blit_pkg::*;
#(
  parameter int W = 16,
  parameter int H = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clear,
  input  logic                en,
  output logic [cnt_w(W)-1:0] cx,
  output logic [cnt_w(H)-1:0] cy,
  output logic                last
);

  localparam int CXW = cnt_w(W);
  localparam int CYW = cnt_w(H);

  logic cx_end;
  logic cy_end;

  assign cx_end = (cx == CXW'(W - 1));
  assign cy_end = (cy == CYW'(H - 1));
  assign last   = cx_end && cy_end;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clear) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (cx_end) begin
        cx <= '0;
        // Wrapping after the final pixel leaves the counter ready for the next blit.
        cy <= cy_end ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite/rectangle blitter: raster-scans SPR_W x SPR_H pixels, one plot strobe per clock.
// Latency: first pixel registered the cycle after start is sampled; done one cycle after the last pixel.
// Backpressure: none; start is only honoured in IDLE, and is dropped (not queued) while busy or done.
//
// Ports: clock, resetn (async, active low); start, x0, y0, erase, color_in in;
//        busy, done, plot, x_out, y_out, color_out out (all registered).
// Optional feature: define BLIT_CLIP_EN to suppress plot for pixels outside the
//        SCREEN_W x SCREEN_H area (wrapped pixels included); scan timing is unchanged.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 16,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int BG_COLOR = 0
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic               erase,
  input  logic [COLOR_W-1:0] color_in,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out
);

  state_t                   state;
  logic                     last_q;   // pixel currently on the outputs is the final one
  logic [X_W-1:0]           x0_l;
  logic [Y_W-1:0]           y0_l;
  logic [COLOR_W-1:0]       color_l;

  logic [cnt_w(SPR_W)-1:0]  cx;
  logic [cnt_w(SPR_H)-1:0]  cy;
  logic                     last;
  logic                     cnt_en;
  logic                     cnt_clear;

  logic [X_W-1:0]           src_x;
  logic [Y_W-1:0]           src_y;
  logic [COLOR_W-1:0]       src_c;
  logic [X_W-1:0]           pix_x;
  logic [Y_W-1:0]           pix_y;
  logic                     pix_vis;

  // The counter always points at the pixel to be emitted on the next edge.
  assign cnt_en    = ((state == IDLE) && start) || ((state == DRAW) && !last_q);
  assign cnt_clear = (state == DONE);

  raster_counter #(
    .W (SPR_W),
    .H (SPR_H)
  ) u_raster_counter (
    .clock  (clock),
    .resetn (resetn),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .cx     (cx),
    .cy     (cy),
    .last   (last)
  );

  // Pixel 0 is emitted on the same edge that samples start, so it is built from
  // the live inputs; later pixels use the latched copies.
  always_comb begin
    src_x = x0_l;
    src_y = y0_l;
    src_c = color_l;
    if (state == IDLE) begin
      src_x = x0;
      src_y = y0;
      src_c = erase ? COLOR_W'(BG_COLOR) : color_in;
    end
  end

`ifdef BLIT_CLIP_EN
  logic [X_W:0] px_w;
  logic [Y_W:0] py_w;

  // One extra bit keeps the carry, so coordinates that wrap are seen as off-screen.
  always_comb begin
    px_w    = {1'b0, src_x} + (X_W + 1)'(cx);
    py_w    = {1'b0, src_y} + (Y_W + 1)'(cy);
    pix_x   = px_w[X_W-1:0];
    pix_y   = py_w[Y_W-1:0];
    pix_vis = (px_w < (X_W + 1)'(SCREEN_W)) && (py_w < (Y_W + 1)'(SCREEN_H));
  end
`else
  always_comb begin
    pix_x   = src_x + X_W'(cx);
    pix_y   = src_y + Y_W'(cy);
    pix_vis = 1'b1;
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      last_q    <= 1'b0;
      x0_l      <= '0;
      y0_l      <= '0;
      color_l   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      plot      <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x0_l      <= x0;
            y0_l      <= y0;
            color_l   <= src_c;
            busy      <= 1'b1;
            plot      <= pix_vis;
            x_out     <= pix_x;
            y_out     <= pix_y;
            color_out <= src_c;
            last_q    <= last;
            state     <= DRAW;
          end
        end

        DRAW: begin
          if (last_q) begin
            busy      <= 1'b0;
            plot      <= 1'b0;
            done      <= 1'b1;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
            last_q    <= 1'b0;
            state     <= DONE;
          end else begin
            plot      <= pix_vis;
            x_out     <= pix_x;
            y_out     <= pix_y;
            color_out <= src_c;
            last_q    <= last;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          plot  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a 4x4 instance and a default 16x16 instance
// share clock, reset and pixel inputs; each has its own start.
module tb_sprite_blitter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start_s, start_b;
  logic [7:0] x0;
  logic [6:0] y0;
  logic       erase;
  logic [2:0] color_in;

  logic       busy_s, done_s, plot_s;
  logic [7:0] x_s;
  logic [6:0] y_s;
  logic [2:0] c_s;

  logic       busy_b, done_b, plot_b;
  logic [7:0] x_b;
  logic [6:0] y_b;
  logic [2:0] c_b;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  sprite_blitter #(.SPR_W(4), .SPR_H(4)) u_small (
    .clock(clock), .resetn(resetn), .start(start_s), .x0(x0), .y0(y0),
    .erase(erase), .color_in(color_in), .busy(busy_s), .done(done_s),
    .plot(plot_s), .x_out(x_s), .y_out(y_s), .color_out(c_s)
  );

  sprite_blitter u_big (
    .clock(clock), .resetn(resetn), .start(start_b), .x0(x0), .y0(y0),
    .erase(erase), .color_in(color_in), .busy(busy_b), .done(done_b),
    .plot(plot_b), .x_out(x_b), .y_out(y_b), .color_out(c_b)
  );

  task automatic test_reset;
    logic [20:0] got;
    resetn = 1'b0; start_s = 1'b0; start_b = 1'b0;
    x0 = 8'd0; y0 = 7'd0; erase = 1'b0; color_in = 3'd0;
    @(negedge clock);
    got = {busy_s, done_s, plot_s, x_s, y_s, c_s};
    tests++;
    if (got !== 21'd0) begin
      fails++; $display("FAIL reset_small: got %h expected 0", got);
    end
    got = {busy_b, done_b, plot_b, x_b, y_b, c_b};
    tests++;
    if (got !== 21'd0) begin
      fails++; $display("FAIL reset_big: got %h expected 0", got);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if ({busy_s, done_s, plot_s} !== 3'b000) begin
      fails++; $display("FAIL idle_after_reset: got %b expected 000", {busy_s, done_s, plot_s});
    end
  endtask

  // Draw then erase on the 4x4 instance; inputs are scrambled after start to
  // confirm they were latched.
  task automatic test_draw_modes;
    logic [20:0] got, exp;
    logic [2:0]  col;
    for (int m = 0; m < 2; m++) begin
      col = (m == 0) ? 3'b101 : 3'b000;
      x0 = 8'd10; y0 = 7'd20; erase = (m == 1); color_in = (m == 0) ? 3'b101 : 3'b111;
      start_s = 1'b1;
      @(negedge clock);
      start_s = 1'b0; x0 = 8'd99; y0 = 7'd99; color_in = 3'b010; erase = (m == 0);
      for (int i = 0; i < 16; i++) begin
        got = {busy_s, done_s, plot_s, x_s, y_s, c_s};
        exp = {1'b1, 1'b0, 1'b1, 8'(10 + i % 4), 7'(20 + i / 4), col};
        tests++;
        if (got !== exp) begin
          fails++; $display("FAIL pixel_mode%0d_%0d: got %h expected %h", m, i, got, exp);
        end
        @(negedge clock);
      end
      tests++;
      if ({busy_s, done_s, plot_s} !== 3'b010) begin
        fails++; $display("FAIL done_pulse_mode%0d: got %b expected 010", m, {busy_s, done_s, plot_s});
      end
      @(negedge clock);
      tests++;
      if ({busy_s, done_s, plot_s} !== 3'b000) begin
        fails++; $display("FAIL done_single_mode%0d: got %b expected 000", m, {busy_s, done_s, plot_s});
      end
    end
  endtask

  // start held through DONE: ignored in DONE, sampled in the following IDLE cycle.
  task automatic test_back_to_back;
    bit found;
    x0 = 8'd10; y0 = 7'd20; erase = 1'b0; color_in = 3'b101;
    start_s = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (done_s) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL b2b_done_timeout: got no done expected done within 40 cycles");
    end
    @(negedge clock);
    tests++;
    if ({busy_s, plot_s} !== 2'b00) begin
      fails++; $display("FAIL b2b_idle_gap: got %b expected 00", {busy_s, plot_s});
    end
    @(negedge clock);
    start_s = 1'b0;
    tests++;
    if ({busy_s, plot_s, x_s, y_s} !== {2'b11, 8'd10, 7'd20}) begin
      fails++; $display("FAIL b2b_restart: got %h expected %h", {busy_s, plot_s, x_s, y_s}, {2'b11, 8'd10, 7'd20});
    end
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (done_s) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL b2b_second_done_timeout: got no done expected done within 40 cycles");
    end
    @(negedge clock);
  endtask

  // start held 40 cycles on the 16x16 instance: one blit, one done.
  task automatic test_long_start;
    int plots = 0;
    int dones = 0;
    x0 = 8'd0; y0 = 7'd0; erase = 1'b0; color_in = 3'b011;
    start_b = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (c == 39) start_b = 1'b0;
      if (plot_b) plots++;
      if (done_b) dones++;
    end
    tests++;
    if (plots != 256) begin
      fails++; $display("FAIL long_start_plots: got %0d expected 256", plots);
    end
    tests++;
    if (dones != 1) begin
      fails++; $display("FAIL long_start_dones: got %0d expected 1", dones);
    end
  endtask

  // Reset asserted while pixel 5 is on the outputs.
  task automatic test_reset_mid;
    int stray = 0;
    bit found;
    x0 = 8'd10; y0 = 7'd20; erase = 1'b0; color_in = 3'b110;
    start_s = 1'b1;
    @(negedge clock);
    start_s = 1'b0;
    repeat (5) @(negedge clock);
    tests++;
    if ({plot_s, x_s, y_s} !== {1'b1, 8'd11, 7'd21}) begin
      fails++; $display("FAIL mid_pixel5: got %h expected %h", {plot_s, x_s, y_s}, {1'b1, 8'd11, 7'd21});
    end
    resetn = 1'b0;
    #1;
    tests++;
    if ({busy_s, done_s, plot_s, x_s, y_s, c_s} !== 21'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got %h expected 0", {busy_s, done_s, plot_s, x_s, y_s, c_s});
    end
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (plot_s || busy_s || done_s) stray++;
    end
    tests++;
    if (stray != 0) begin
      fails++; $display("FAIL mid_reset_stays_idle: got %0d active cycles expected 0", stray);
    end
    start_s = 1'b1;
    @(negedge clock);
    start_s = 1'b0;
    tests++;
    if ({plot_s, x_s, y_s, c_s} !== {1'b1, 8'd10, 7'd20, 3'b110}) begin
      fails++; $display("FAIL mid_reset_new_blit: got %h expected %h", {plot_s, x_s, y_s, c_s}, {1'b1, 8'd10, 7'd20, 3'b110});
    end
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (done_s) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL mid_reset_done_timeout: got no done expected done within 40 cycles");
    end
    @(negedge clock);
  endtask

  // Coordinate wrap (default build) or screen clipping (BLIT_CLIP_EN) on 16x16.
  task automatic test_wrap_clip;
    int xs;
    logic [19:0] got, exp;
    logic        vis;
`ifdef BLIT_CLIP_EN
    xs = 155;
`else
    xs = 250;
`endif
    x0 = 8'(xs); y0 = 7'd5; erase = 1'b0; color_in = 3'b010;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    for (int i = 0; i < 256; i++) begin
`ifdef BLIT_CLIP_EN
      vis = (xs + i % 16) < 160;
`else
      vis = 1'b1;
`endif
      got = {busy_b, plot_b, x_b, y_b, c_b};
      exp = {1'b1, vis, 8'(xs + i % 16), 7'(5 + i / 16), 3'b010};
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL wrap_clip_pixel_%0d: got %h expected %h", i, got, exp);
      end
      @(negedge clock);
    end
    tests++;
    if ({busy_b, done_b, plot_b} !== 3'b010) begin
      fails++; $display("FAIL wrap_clip_done: got %b expected 010", {busy_b, done_b, plot_b});
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_draw_modes();
    test_back_to_back();
    test_long_start();
    test_reset_mid();
    test_wrap_clip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
